// File: rtl/keypad_scanner_if.sv
// Keypad matrix bundle: column sense lines in, row strobes and key report out.
// Latency: none, wires only.
// Backpressure: none; key_det/key_code are levels consumed by the debounce stage.
interface keypad_scanner_if;
    logic [3:0] col_in;     // active-low columns, pulled up externally
    logic [3:0] row_out;    // active-low one-hot row strobes
    logic       key_det;    // high while a key is held and frozen
    logic [3:0] key_code;   // last detected key, holds after release

    // scanner side
    modport master (
        input  col_in,
        output row_out,
        output key_det,
        output key_code
    );

    // keypad / downstream side
    modport slave (
        output col_in,
        input  row_out,
        input  key_det,
        input  key_code
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: strobes rows, samples synchronized columns, freezes on a key.
// Latency: key_det/key_code update on the edge ending a row's DWELL-th cycle (<= DWELL+2 from col_in).
// Backpressure: none; outputs are levels, downstream debounce samples them at will.
module keypad_scanner #(
    parameter int DWELL = 4000
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       row_idx;
    logic [1:0]       row_idx_nxt;
    logic [3:0]       key_code_q;
    logic [3:0]       key_code_nxt;
    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic             sample_pt;
    logic             col_idle;

    // Row (r) and lowest low column (col0 wins) to keypad legend code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [3:0] cols);
        logic [1:0] c;
        logic [3:0] code;
        if (!cols[0])      c = 2'd0;
        else if (!cols[1]) c = 2'd1;
        else if (!cols[2]) c = 2'd2;
        else               c = 2'd3;
        case ({row, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;   // '*'
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;   // '#'
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; idle (all high) out of reset so no phantom key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= kp.col_in;
            col_s    <= col_meta;
        end
    end

    // Columns are only looked at on the last cycle of each dwell window.
    assign sample_pt = (cnt == CNT_LAST);
    assign col_idle  = (col_s == 4'hF);

    // State and scan datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            cnt        <= '0;
            row_idx    <= 2'd0;
            key_code_q <= 4'h0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            row_idx    <= row_idx_nxt;
            key_code_q <= key_code_nxt;
        end
    end

    // Next state: advance row on an idle sample, freeze and capture on a press,
    // and leave HOLD only after an all-high sample (so a key swap on the same row is ignored).
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        row_idx_nxt  = row_idx;
        key_code_nxt = key_code_q;
        if (sample_pt) begin
            cnt_nxt = '0;
            case (state)
                SCAN: begin
                    if (col_idle) begin
                        row_idx_nxt = row_idx + 2'd1;
                    end else begin
                        state_nxt    = HOLD;
                        key_code_nxt = key_map(row_idx, col_s);
                    end
                end
                HOLD: begin
                    if (col_idle) begin
                        state_nxt   = SCAN;
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // Outputs decode straight from flops, so they are glitch-free registered levels.
    always_comb begin
        kp.row_out  = ~(4'b0001 << row_idx);
        kp.key_det  = (state == HOLD);
        kp.key_code = key_code_q;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and a reference model.
// Latency: checks sampled on the falling edge, half a cycle after each update.
// Backpressure: n/a.
module tb_keypad_scanner;
    localparam int DWELL = 8;

    logic        clk;
    logic        reset;
    logic [15:0] key_down;   // bit r*4+c: key at row r, column c is held
    logic [3:0]  glitch;     // forces columns low regardless of rows
    logic [3:0]  col_kp;
    int          n_cmp;
    int          n_err;

    keypad_scanner_if kif ();

    keypad_scanner #(.DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a held key shorts its column to its row strobe.
    always_comb begin
        col_kp = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !kif.row_out[r]) col_kp[c] = 1'b0;
        kif.col_in = col_kp & ~glitch;
    end

    // Reference model: columns seen two edges late, judged once every DWELL cycles.
    logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};
    int         m_tick;
    int         m_row;
    bit         m_hold;
    logic [3:0] m_code;
    logic [3:0] m_d0, m_d1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tick = 0; m_row = 0; m_hold = 0; m_code = 4'h0;
            m_d0 = 4'hF; m_d1 = 4'hF;
        end else begin
            if (m_tick == DWELL - 1) begin
                m_tick = 0;
                if (m_d1 == 4'hF) begin
                    m_hold = 0;
                    m_row  = (m_row + 1) % 4;
                end else if (!m_hold) begin
                    int lo;
                    lo = 3;
                    for (int c = 3; c >= 0; c--) if (!m_d1[c]) lo = c;
                    m_hold = 1;
                    m_code = KEYMAP[m_row*4 + lo];
                end
            end else begin
                m_tick++;
            end
            m_d1 = m_d0;
            m_d0 = kif.col_in;
        end
    end

    function automatic logic [3:0] row_strobe(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic test_reset();
        reset = 1'b1; key_down = '0; glitch = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (kif.row_out !== 4'b1110) begin n_err++; $display("FAIL reset_row_out got=%b want=1110", kif.row_out); end
        n_cmp++; if (kif.key_det !== 1'b0) begin n_err++; $display("FAIL reset_key_det got=%b want=0", kif.key_det); end
        n_cmp++; if (kif.key_code !== 4'h0) begin n_err++; $display("FAIL reset_key_code got=%h want=0", kif.key_code); end
        reset = 1'b0;
    endtask

    // Starts right at reset release: row r is driven for edges r*DWELL+1 .. (r+1)*DWELL.
    task automatic test_idle();
        logic [3:0] exp_row;
        for (int j = 1; j <= 5*DWELL; j++) begin
            @(negedge clk);
            exp_row = row_strobe((j / DWELL) % 4);
            n_cmp++; if (kif.row_out !== exp_row) begin n_err++; $display("FAIL idle_row_out cyc=%0d got=%b want=%b", j, kif.row_out, exp_row); end
            n_cmp++; if (kif.key_det !== 1'b0) begin n_err++; $display("FAIL idle_key_det cyc=%0d got=%b want=0", j, kif.key_det); end
            n_cmp++; if (kif.key_code !== 4'h0) begin n_err++; $display("FAIL idle_key_code cyc=%0d got=%h want=0", j, kif.key_code); end
        end
    endtask

    task automatic test_press(input logic [15:0] keys, input int row, input logic [3:0] exp_code, input string name);
        int waited;
        @(negedge clk);
        key_down = keys;
        waited = 0;
        while (kif.key_det !== 1'b1 && waited < 4*DWELL + 4) begin
            @(negedge clk); waited++;
            n_cmp++; if (kif.row_out !== row_strobe(m_row)) begin n_err++; $display("FAIL %s_scan_row got=%b want=%b", name, kif.row_out, row_strobe(m_row)); end
        end
        n_cmp++; if (kif.key_det !== 1'b1) begin n_err++; $display("FAIL %s_detect_timeout got=%b want=1", name, kif.key_det); end
        n_cmp++; if (kif.key_code !== exp_code) begin n_err++; $display("FAIL %s_code got=%h want=%h", name, kif.key_code, exp_code); end
        repeat (2*DWELL + 3) begin
            @(negedge clk);
            n_cmp++; if (kif.row_out !== row_strobe(row) || kif.key_det !== 1'b1) begin
                n_err++; $display("FAIL %s_frozen row=%b det=%b want row=%b det=1", name, kif.row_out, kif.key_det, row_strobe(row));
            end
        end
        key_down = '0;
        waited = 0;
        while (kif.key_det === 1'b1 && waited < DWELL + 3) begin @(negedge clk); waited++; end
        n_cmp++; if (kif.key_det !== 1'b0 || waited > DWELL + 2) begin
            n_err++; $display("FAIL %s_release det=%b cycles=%0d want det=0 within %0d", name, kif.key_det, waited, DWELL + 2);
        end
        n_cmp++; if (kif.row_out !== row_strobe((row + 1) % 4)) begin n_err++; $display("FAIL %s_row_after_release got=%b want=%b", name, kif.row_out, row_strobe((row + 1) % 4)); end
        n_cmp++; if (kif.key_code !== exp_code) begin n_err++; $display("FAIL %s_code_holds got=%h want=%h", name, kif.key_code, exp_code); end
    endtask

    // Swap to another key on the held row without an idle gap: no new code.
    task automatic test_hold_other_key();
        int waited;
        @(negedge clk);
        key_down = 16'h0010;                  // r1,c0 = '4'
        waited = 0;
        while (kif.key_det !== 1'b1 && waited < 4*DWELL + 4) begin @(negedge clk); waited++; end
        n_cmp++; if (kif.key_det !== 1'b1 || kif.key_code !== 4'h4) begin n_err++; $display("FAIL swap_first det=%b code=%h want det=1 code=4", kif.key_det, kif.key_code); end
        key_down = 16'h0040;                  // r1,c2 = '6'
        repeat (3*DWELL) @(negedge clk);
        n_cmp++; if (kif.key_det !== 1'b1 || kif.key_code !== 4'h4) begin n_err++; $display("FAIL swap_no_new_code det=%b code=%h want det=1 code=4", kif.key_det, kif.key_code); end
        key_down = '0;
        repeat (DWELL + 3) @(negedge clk);
        n_cmp++; if (kif.key_det !== 1'b0) begin n_err++; $display("FAIL swap_release det=%b want=0", kif.key_det); end
    endtask

    task automatic test_glitch();
        int waited;
        waited = 0;
        while (m_tick != 1 && waited < 2*DWELL) begin @(negedge clk); waited++; end
        n_cmp++; if (m_tick != 1) begin n_err++; $display("FAIL glitch_align tick=%0d want=1", m_tick); end
        glitch = 4'b0101;
        repeat (2) @(negedge clk);
        glitch = 4'b0000;
        repeat (2*DWELL) begin
            @(negedge clk);
            n_cmp++; if (kif.key_det !== 1'b0 || kif.row_out !== row_strobe(m_row)) begin
                n_err++; $display("FAIL glitch_ignored det=%b row=%b want det=0 row=%b", kif.key_det, kif.row_out, row_strobe(m_row));
            end
        end
    endtask

    task automatic test_reset_in_hold();
        int waited;
        @(negedge clk);
        key_down = 16'h0100;                  // r2,c0 = '7'
        waited = 0;
        while (kif.key_det !== 1'b1 && waited < 4*DWELL + 4) begin @(negedge clk); waited++; end
        n_cmp++; if (kif.key_det !== 1'b1 || kif.key_code !== 4'h7) begin n_err++; $display("FAIL rsthold_detect det=%b code=%h want det=1 code=7", kif.key_det, kif.key_code); end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (kif.key_det !== 1'b0) begin n_err++; $display("FAIL rsthold_key_det got=%b want=0", kif.key_det); end
        n_cmp++; if (kif.row_out !== 4'b1110) begin n_err++; $display("FAIL rsthold_row_out got=%b want=1110", kif.row_out); end
        n_cmp++; if (dut.cnt !== '0) begin n_err++; $display("FAIL rsthold_cnt got=%0d want=0", dut.cnt); end
        @(negedge clk);
        reset = 1'b0;
        waited = 0;
        while (kif.key_det !== 1'b1 && waited < 4*DWELL + 4) begin @(negedge clk); waited++; end
        n_cmp++; if (kif.key_det !== 1'b1 || waited != 3*DWELL) begin n_err++; $display("FAIL rsthold_redetect det=%b cycles=%0d want det=1 at %0d", kif.key_det, waited, 3*DWELL); end
        n_cmp++; if (kif.key_code !== 4'h7 || kif.row_out !== 4'b1011) begin n_err++; $display("FAIL rsthold_recode code=%h row=%b want code=7 row=1011", kif.key_code, kif.row_out); end
        key_down = '0;
        repeat (DWELL + 3) @(negedge clk);
    endtask

    // Random keys, durations and stray column glitches checked every cycle against the model.
    task automatic test_random();
        int hold_len;
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            key_down = ($urandom_range(0, 5) == 0) ? 16'h0 : (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) key_down = key_down | (16'h1 << $urandom_range(0, 15));
            hold_len = DWELL * $urandom_range(1, 5) + $urandom_range(0, DWELL - 1);
            for (int k = 0; k < hold_len; k++) begin
                glitch = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                @(negedge clk);
                n_cmp++; if (kif.row_out !== row_strobe(m_row)) begin n_err++; $display("FAIL rand_row it=%0d got=%b want=%b", it, kif.row_out, row_strobe(m_row)); end
                n_cmp++; if (kif.key_det !== m_hold) begin n_err++; $display("FAIL rand_det it=%0d got=%b want=%b", it, kif.key_det, m_hold); end
                n_cmp++; if (kif.key_code !== m_code) begin n_err++; $display("FAIL rand_code it=%0d got=%h want=%h", it, kif.key_code, m_code); end
            end
            glitch = 4'h0;
            if ($urandom_range(0, 1) == 0) begin
                key_down = '0;
                repeat ($urandom_range(1, 3*DWELL)) @(negedge clk);
            end
        end
        key_down = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        key_down = '0;
        glitch = '0;
        test_reset();
        test_idle();
        test_press(16'h0020, 1, 4'h5, "key5");       // r1,c1
        test_press(16'h4000, 3, 4'hF, "key_hash");   // r3,c2
        test_press(16'h1000, 3, 4'hE, "key_star");   // r3,c0
        test_press(16'h0A00, 2, 4'h8, "multi_col");  // r2,c1 + r2,c3
        test_press(16'h0008, 0, 4'hA, "key_a");      // r0,c3
        test_hold_other_key();
        test_glitch();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Row-drive and column-sense front end for the 4x4 matrix keypad on the wb_teclado path. It walks an active-low strobe across the four rows, samples the four pulled-up column lines, and reports the pressed key as a raw level `key_det` plus a 4-bit `key_code`. `key_det` and `key_code` feed `btn_in` and `data_in` of the keypad debounce stage. Debouncing and digit counting happen downstream; this block only scans, freezes on a key, and reports.

## Interface
- `DWELL`, default 4000: clock cycles each row is driven before its columns are sampled; legal range ≥ 4.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `col_in`  in  4  keypad columns, active-low (external pull-ups), asynchronous to `clk`.
- `row_out`  out  4  row strobes, active-low one-hot.
- `key_det`  out  1  high while a key is held and frozen.
- `key_code`  out  4  code of the last detected key; valid while `key_det`=1, holds after release.

## Operation
- Column synchronizer: 2-flop synchronizer on `col_in` produces `col_s`. Reset value is 4'b1111.
- Registers:
  - `row_idx` (2 bits, wraps 3→0). `row_out` = ~(1<<`row_idx`).
  - `cnt`, sized to hold DWELL-1.
  - `state` ∈ {SCAN, HOLD}.
- Reset values:
  - `state`=SCAN, `row_idx`=0, `row_out`=4'b1110.
  - `cnt`=0, `key_det`=0, `key_code`=4'h0.
  - Reset applies immediately, mid-scan or mid-hold.
- SCAN state:
  - `cnt` increments each cycle.
  - When `cnt`==DWELL-1, `cnt`←0 and `col_s` is evaluated:
    - `col_s`==4'hF: `row_idx`←`row_idx`+1.
    - Otherwise: go to HOLD, `row_idx` unchanged, `key_det`←1, `key_code`←map(`row_idx`, c). c is the lowest-index low column; col0 has priority when several columns are low.
- HOLD state:
  - `row_out` stays frozen; `cnt` increments.
  - When `cnt`==DWELL-1, `cnt`←0 and `col_s` is evaluated:
    - `col_s`==4'hF: `key_det`←0, go to SCAN, `row_idx`←`row_idx`+1.
    - Otherwise: stay in HOLD; `key_code` is not updated. A different key on the same row with no all-high sample in between gives no new code.
- Key map (row,col → code):
  - r0: 1,2,3,A.
  - r1: 4,5,6,B.
  - r2: 7,8,9,C.
  - r3: `*`=E, 0=0, `#`=F, D=D.
- `col_s` is never sampled except at `cnt`==DWELL-1. Glitches between sample points are ignored.

## Timing
- A full scan period with no key pressed is 4·DWELL cycles.
- Row change: `row_out` changes on the clock edge after the sample cycle. The new row then settles for DWELL cycles before its own sample. Settle time must exceed the 2-cycle synchronizer latency plus pad delay.
- Detection latency: `key_det` and `key_code` are registered. They update on the same edge that ends the sample cycle, i.e. the edge where `cnt` would wrap.
- From `col_in` going low on the active row to `key_det`=1: at most DWELL+2 cycles.
- Release latency: from `col_in` going all-high to `key_det`=0 is at most DWELL+2 cycles. `row_out` advances on that same edge.
- `key_code` changes only on the rising edge of `key_det`; it is stable for the whole high period.

## Test plan
- Idle: reset with `col_in`=4'hF, DWELL=8 → `row_out` steps 1110→1101→1011→0111→1110, 8 cycles each; `key_det` stays 0; `key_code`=0.
- Press '5': keypad model holds row1/col1 → `col_in`=4'b1101 while `row_out`=1101 → `key_det`=1 at the row1 sample edge, `key_code`=4'h5, `row_out` frozen at 1101. Release → `key_det`=0 within 10 cycles, `row_out`→1011.
- Press '#' (r3,c2) → `key_code`=4'hF. Press '\*' (r3,c0) → `key_code`=4'hE. After release, `key_code` holds its last value.
- Multiple columns: r2,c1 and r2,c3 pressed together → `key_code`=4'h8 (col1 wins).
- Glitch: `col_in` pulses low for 2 cycles mid-dwell, away from the sample point → no detection; scan continues.
- Async reset asserted in HOLD with a key down → `key_det`=0, `row_out`=1110, `cnt`=0 immediately. After reset is released, the key is re-detected on its row's next sample.
